// File: rtl/biriscv_fetch_buf_pkg.sv
// Shared types for the fetch buffer: one queue slot per live instruction.
package biriscv_fetch_buf_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               pred_branch;
    logic               fault_fetch;
    logic               fault_page;
  } fetch_slot_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/biriscv_lane_compact.sv
// Contiguous live-lane run from an offset, stopping after a cut lane or at the first disabled lane.
module biriscv_lane_compact #(
  parameter int LANES = 2,
  parameter int OFF_W = 1,
  parameter int CNT_W = 2
) (
  input  logic [OFF_W-1:0]       offset_i,
  input  logic [LANES-1:0]       en_i,
  input  logic [LANES-1:0]       cut_i,
  output logic [LANES-1:0]       live_o,
  output logic [CNT_W-1:0]       count_o,
  output logic [LANES*OFF_W-1:0] order_o
);

  always_comb begin
    logic run;
    live_o  = '0;
    count_o = '0;
    order_o = '0;
    run     = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      if (k >= int'(offset_i)) begin
        if (run && en_i[k]) begin
          live_o[k] = 1'b1;
          count_o   = count_o + CNT_W'(1);
        end else begin
          run = 1'b0;
        end
        // a cut lane is itself live; only the lanes after it are dropped
        if (cut_i[k]) run = 1'b0;
      end
      order_o[k*OFF_W +: OFF_W] = offset_i + OFF_W'(k);
    end
  end

endmodule

// File: rtl/biriscv_fetch_buffer.sv
// Fetch-to-issue instruction queue with entry/branch trimming and per-lane in-order pop.
// Optional same-cycle bypass when empty: define BIRISCV_FETCH_BUF_BYPASS_EN.
module biriscv_fetch_buffer
  import biriscv_fetch_buf_pkg::*;
#(
  parameter int FETCH_LANES = 2,
  parameter int ISSUE_LANES = 2,
  parameter int DEPTH       = 8,
  parameter int DEPTH_W     = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           fetch_valid_i,
  input  logic [INSTR_W*FETCH_LANES-1:0] fetch_instr_i,
  input  logic [PC_W-1:0]                fetch_pc_i,
  input  logic [FETCH_LANES-1:0]         fetch_pred_branch_i,
  input  logic                           fetch_fault_fetch_i,
  input  logic                           fetch_fault_page_i,
  output logic                           fetch_accept_o,
  input  logic                           flush_i,
  output logic [ISSUE_LANES-1:0]         out_valid_o,
  output logic [INSTR_W*ISSUE_LANES-1:0] out_instr_o,
  output logic [PC_W*ISSUE_LANES-1:0]    out_pc_o,
  output logic [ISSUE_LANES-1:0]         out_pred_branch_o,
  output logic [ISSUE_LANES-1:0]         out_fault_fetch_o,
  output logic [ISSUE_LANES-1:0]         out_fault_page_o,
  input  logic [ISSUE_LANES-1:0]         out_accept_i,
  output logic [DEPTH_W:0]               level_o
);

  localparam int FOFF_W = (clog2(FETCH_LANES) > 0) ? clog2(FETCH_LANES) : 1;
  localparam int IOFF_W = (clog2(ISSUE_LANES) > 0) ? clog2(ISSUE_LANES) : 1;
  localparam int FCNT_W = clog2(FETCH_LANES) + 1;
  localparam int ICNT_W = clog2(ISSUE_LANES) + 1;
  localparam int PS     = (FETCH_LANES > ISSUE_LANES) ? FETCH_LANES : ISSUE_LANES;
  localparam logic [DEPTH_W:0] DEPTH_L = (DEPTH_W+1)'(DEPTH);
  localparam logic [DEPTH_W:0] FL_L    = (DEPTH_W+1)'(FETCH_LANES);

  fetch_slot_t                   mem_q [DEPTH];
  logic [DEPTH_W-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W:0]              level_q, level_d;
  logic [FOFF_W-1:0]             fetch_off;
  logic [FETCH_LANES-1:0]        fetch_live;
  logic [FCNT_W-1:0]             fetch_cnt, push_cnt, wr_skip, wr_cnt;
  logic [FETCH_LANES*FOFF_W-1:0] fetch_order;
  fetch_slot_t                   push_slot [PS];
  fetch_slot_t                   wr_slot [FETCH_LANES];
  logic                          fetch_fault, bypass_act;
  logic [ISSUE_LANES-1:0]        pop_en, pop_live, out_valid;
  logic [ICNT_W-1:0]             pop_cnt, rd_cnt;
  logic [ISSUE_LANES*IOFF_W-1:0] pop_order;
  fetch_slot_t                   out_slot [ISSUE_LANES];
  logic                          unused_bits;

  assign fetch_off   = fetch_pc_i[2 +: FOFF_W];
  assign fetch_fault = fetch_fault_fetch_i | fetch_fault_page_i;
  // Pop in the same cycle is deliberately not credited, keeping accept off the issue path.
  assign fetch_accept_o = rst_i & fetch_valid_i & ((DEPTH_L - level_q) >= FL_L);

  biriscv_lane_compact #(.LANES(FETCH_LANES), .OFF_W(FOFF_W), .CNT_W(FCNT_W)) u_fetch_compact (
    .offset_i (fetch_off),
    .en_i     ({FETCH_LANES{1'b1}}),
    .cut_i    (fetch_pred_branch_i),
    .live_o   (fetch_live),
    .count_o  (fetch_cnt),
    .order_o  (fetch_order)
  );

  always_comb begin
    logic [FOFF_W-1:0] src;
    for (int j = 0; j < PS; j++) push_slot[j] = '0;
    for (int j = 0; j < FETCH_LANES; j++) begin
      src = fetch_order[j*FOFF_W +: FOFF_W];
      push_slot[j].instr       = fetch_instr_i[INSTR_W*src +: INSTR_W];
      push_slot[j].pc          = {fetch_pc_i[PC_W-1:FOFF_W+2], src, 2'b00};
      push_slot[j].pred_branch = fetch_pred_branch_i[src];
    end
    push_cnt = fetch_cnt;
    if (fetch_fault) begin
      push_slot[0]             = '0;
      push_slot[0].pc          = fetch_pc_i;
      push_slot[0].fault_fetch = fetch_fault_fetch_i;
      push_slot[0].fault_page  = fetch_fault_page_i;
      push_cnt                 = FCNT_W'(1);
    end
  end

  always_comb begin
    logic blocked;
    blocked    = 1'b0;
    bypass_act = 1'b0;
    for (int k = 0; k < ISSUE_LANES; k++) begin
      out_slot[k]  = mem_q[rd_ptr_q + DEPTH_W'(k)];
      out_valid[k] = 1'b0;
      if (int'(level_q) > k) begin
        // a fault slot may only issue alone on lane 0
        if (k > 0 && (out_slot[k].fault_fetch || out_slot[k].fault_page)) blocked = 1'b1;
        out_valid[k] = ~blocked;
      end
    end
`ifdef BIRISCV_FETCH_BUF_BYPASS_EN
    bypass_act = (level_q == '0) & fetch_accept_o & ~flush_i;
    if (bypass_act) begin
      for (int k = 0; k < ISSUE_LANES; k++) begin
        out_slot[k]  = push_slot[k];
        out_valid[k] = (int'(push_cnt) > k);
      end
    end
`endif
  end

  always_comb begin
    for (int k = 0; k < ISSUE_LANES; k++) begin
      out_valid_o[k]                     = out_valid[k];
      out_instr_o[k*INSTR_W +: INSTR_W]  = out_valid[k] ? out_slot[k].instr : '0;
      out_pc_o[k*PC_W +: PC_W]           = out_valid[k] ? out_slot[k].pc : '0;
      out_pred_branch_o[k]               = out_valid[k] & out_slot[k].pred_branch;
      out_fault_fetch_o[k]               = out_valid[k] & out_slot[k].fault_fetch;
      out_fault_page_o[k]                = out_valid[k] & out_slot[k].fault_page;
    end
  end

  assign pop_en = out_valid_o & out_accept_i;

  biriscv_lane_compact #(.LANES(ISSUE_LANES), .OFF_W(IOFF_W), .CNT_W(ICNT_W)) u_pop_compact (
    .offset_i ('0),
    .en_i     (pop_en),
    .cut_i    ('0),
    .live_o   (pop_live),
    .count_o  (pop_cnt),
    .order_o  (pop_order)
  );

  always_comb begin
    // bypassed lanes taken by issue never enter the queue
    wr_skip = bypass_act ? FCNT_W'(pop_cnt) : '0;
    wr_cnt  = (fetch_accept_o & ~flush_i) ? (push_cnt - wr_skip) : '0;
    rd_cnt  = bypass_act ? '0 : pop_cnt;
    for (int j = 0; j < FETCH_LANES; j++) begin
      wr_slot[j] = (j + int'(wr_skip) < PS) ? push_slot[j + int'(wr_skip)] : '0;
    end
    wr_ptr_d = wr_ptr_q + DEPTH_W'(wr_cnt);
    rd_ptr_d = rd_ptr_q + DEPTH_W'(rd_cnt);
    level_d  = level_q + (DEPTH_W+1)'(wr_cnt) - (DEPTH_W+1)'(rd_cnt);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int j = 0; j < FETCH_LANES; j++) begin
      if (int'(wr_cnt) > j) mem_q[wr_ptr_q + DEPTH_W'(j)] <= wr_slot[j];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  assign level_o     = level_q;
  assign unused_bits = ^{fetch_live, pop_live, pop_order};

endmodule

// File: tb/tb_biriscv_fetch_buffer.sv
// Scoreboard bench for biriscv_fetch_buffer (default build, 1-cycle latency).
`timescale 1ns/1ps
module tb_biriscv_fetch_buffer;
  import biriscv_fetch_buf_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic [63:0] fetch_instr_i = '0;
  logic [31:0] fetch_pc_i = '0;
  logic [1:0]  fetch_pred_branch_i = '0;
  logic        fetch_fault_fetch_i = 1'b0;
  logic        fetch_fault_page_i = 1'b0;
  logic        fetch_accept_o;
  logic        flush_i = 1'b0;
  logic [1:0]  out_valid_o;
  logic [63:0] out_instr_o;
  logic [63:0] out_pc_o;
  logic [1:0]  out_pred_branch_o, out_fault_fetch_o, out_fault_page_o;
  logic [1:0]  out_accept_i = '0;
  logic [3:0]  level_o;

  int n_checks = 0;
  int n_errors = 0;
  fetch_slot_t q[$];
  logic        seq_on = 1'b0;
  logic [31:0] next_pc = '0;

  always #5 clk_i = ~clk_i;

  biriscv_fetch_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fetch_valid_i(fetch_valid_i), .fetch_instr_i(fetch_instr_i), .fetch_pc_i(fetch_pc_i),
    .fetch_pred_branch_i(fetch_pred_branch_i), .fetch_fault_fetch_i(fetch_fault_fetch_i),
    .fetch_fault_page_i(fetch_fault_page_i), .fetch_accept_o(fetch_accept_o), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_instr_o(out_instr_o), .out_pc_o(out_pc_o),
    .out_pred_branch_o(out_pred_branch_o), .out_fault_fetch_o(out_fault_fetch_o),
    .out_fault_page_o(out_fault_page_o), .out_accept_i(out_accept_i), .level_o(level_o)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_push();
    fetch_slot_t s;
    if (fetch_fault_fetch_i || fetch_fault_page_i) begin
      s = '0;
      s.pc = fetch_pc_i;
      s.fault_fetch = fetch_fault_fetch_i;
      s.fault_page = fetch_fault_page_i;
      q.push_back(s);
    end else begin
      for (int k = int'(fetch_pc_i[2]); k < 2; k++) begin
        s = '0;
        s.instr = fetch_instr_i[32*k +: 32];
        s.pc = {fetch_pc_i[31:3], 3'b000} + 32'(4*k);
        s.pred_branch = fetch_pred_branch_i[k];
        q.push_back(s);
        if (fetch_pred_branch_i[k]) break;
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_acc"}, fetch_accept_o, 0);
    chk({tag, "_lvl"}, level_o, 0);
    chk({tag, "_vld"}, out_valid_o, 0);
    chk({tag, "_data"}, {out_instr_o, out_pc_o}, 0);
    chk({tag, "_flags"}, {out_pred_branch_o, out_fault_fetch_o, out_fault_page_o}, 0);
  endtask

  // compare at negedge, update model at posedge, return at posedge+1
  task automatic step();
    int n, pop;
    logic [1:0] ev;
    logic blocked, ea;
    fetch_slot_t obs;
    @(negedge clk_i);
    n  = q.size();
    ea = fetch_valid_i && (8 - n >= 2);
    chk("fetch_accept", fetch_accept_o, ea);
    chk("level", level_o, n);
    blocked = 1'b0;
    ev = '0;
    for (int k = 0; k < 2; k++) begin
      if (k < n) begin
        if (k > 0 && (q[k].fault_fetch || q[k].fault_page)) blocked = 1'b1;
        ev[k] = !blocked;
      end
    end
    chk("out_valid", out_valid_o, ev);
    pop = 0;
    for (int k = 0; k < 2; k++) begin
      if (ev[k]) begin
        obs = {out_instr_o[32*k +: 32], out_pc_o[32*k +: 32], out_pred_branch_o[k],
               out_fault_fetch_o[k], out_fault_page_o[k]};
        chk($sformatf("lane%0d_slot", k), obs, q[k]);
        if (out_accept_i[k] && pop == k) begin
          pop++;
          if (seq_on) begin
            chk("seq_pc", obs.pc, next_pc);
            next_pc = next_pc + 4;
          end
        end
      end
    end
    @(posedge clk_i);
    if (flush_i) q.delete();
    else begin
      for (int k = 0; k < pop; k++) void'(q.pop_front());
      if (ea) model_push();
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [63:0] instr,
                       input logic [1:0] pred, input logic ff, input logic fp,
                       input logic [1:0] acc, input logic fl);
    fetch_valid_i = v; fetch_pc_i = pc; fetch_instr_i = instr;
    fetch_pred_branch_i = pred; fetch_fault_fetch_i = ff; fetch_fault_page_i = fp;
    out_accept_i = acc; flush_i = fl;
    step();
  endtask

  initial begin
    fetch_valid_i = 1'b1;
    fetch_pc_i = 32'h8000_0000;
    fetch_instr_i = 64'h1234_5678_9abc_def0;
    #2 chk_reset("reset");
    #10 fetch_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // aligned push
    drive(1, 32'h8000_0000, {32'h0020_0113, 32'h0010_0093}, 2'b00, 0, 0, 2'b00, 0);
    chk("aligned_lvl", level_o, 2);
    chk("aligned_pc", out_pc_o, {32'h8000_0004, 32'h8000_0000});
    chk("aligned_instr", out_instr_o, {32'h0020_0113, 32'h0010_0093});
    drive(0, 0, 0, 2'b00, 0, 0, 2'b11, 0);

    // mid-packet entry
    drive(1, 32'h8000_0004, {32'h0030_0193, 32'h0040_0213}, 2'b00, 0, 0, 2'b00, 0);
    chk("mid_lvl", level_o, 1);
    chk("mid_vld", out_valid_o, 2'b01);
    chk("mid_pc", out_pc_o[31:0], 32'h8000_0004);
    chk("mid_instr", out_instr_o[31:0], 32'h0030_0193);
    drive(0, 0, 0, 2'b00, 0, 0, 2'b01, 0);

    // predicted-taken cut
    drive(1, 32'h8000_0010, {32'h0050_0293, 32'h0060_0313}, 2'b01, 0, 0, 2'b00, 0);
    chk("pred_lvl", level_o, 1);
    chk("pred_bit", out_pred_branch_o, 2'b01);
    drive(0, 0, 0, 2'b00, 0, 0, 2'b11, 0);

    // fill to full, then partial and full drains
    for (int i = 0; i < 4; i++)
      drive(1, 32'h8000_0100 + 32'(8*i), {32'h100 + 32'(i), 32'h200 + 32'(i)}, 2'b00, 0, 0, 2'b00, 0);
    chk("full_lvl", level_o, 8);
    chk("full_acc", fetch_accept_o, 0);
    drive(0, 0, 0, 2'b00, 0, 0, 2'b01, 0);
    chk("drain1_lvl", level_o, 7);
    fetch_valid_i = 1'b1; #1;
    chk("drain1_acc", fetch_accept_o, 0);
    drive(0, 0, 0, 2'b00, 0, 0, 2'b11, 0);
    chk("drain2_lvl", level_o, 5);
    fetch_valid_i = 1'b1; #1;
    chk("drain2_acc", fetch_accept_o, 1);

    // flush beats simultaneous push and pop
    drive(1, 32'h8000_0200, 64'h1111_2222_3333_4444, 2'b00, 0, 0, 2'b11, 1);
    chk("flush_lvl", level_o, 0);
    chk("flush_vld", out_valid_o, 0);

    // fault slot waits for lane 0
    drive(1, 32'h8000_0000, {32'hdead_0001, 32'h0070_0393}, 2'b01, 0, 0, 2'b00, 0);
    drive(1, 32'h8000_1000, {32'hdead_0002, 32'hdead_0003}, 2'b00, 0, 1, 2'b00, 0);
    chk("fault_vld", out_valid_o, 2'b01);
    drive(0, 0, 0, 2'b00, 0, 0, 2'b11, 0);
    chk("fault_pc", out_pc_o[31:0], 32'h8000_1000);
    chk("fault_instr", out_instr_o[31:0], 0);
    chk("fault_page", out_fault_page_o, 2'b01);
    drive(0, 0, 0, 2'b00, 0, 0, 2'b01, 0);

    // streaming across pointer wrap
    seq_on = 1'b1;
    next_pc = 32'h8000_2000;
    for (int i = 0; i < 20; i++)
      drive(1, 32'h8000_2000 + 32'(8*i), {32'(2*i+1), 32'(2*i)}, 2'b00, 0, 0, 2'b11, 0);
    drive(0, 0, 0, 2'b00, 0, 0, 2'b11, 0);
    drive(0, 0, 0, 2'b00, 0, 0, 2'b11, 0);
    chk("stream_end_pc", next_pc, 32'h8000_2000 + 32'(8*20));
    seq_on = 1'b0;

    // randomized mix
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 3) != 0),
            32'h8000_0000 | ($urandom & 32'h0000_fff8) | (32'($urandom_range(0, 1)) << 2),
            {$urandom, $urandom}, 2'($urandom_range(0, 3) == 0 ? 1 : 0),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 19) == 0));
    end

    // reset mid-operation
    drive(1, 32'h8000_3000, 64'h5555_6666_7777_8888, 2'b00, 0, 0, 2'b00, 0);
    fetch_valid_i = 1'b1;
    rst_i = 1'b0;
    #2 chk_reset("midrst");
    q.delete();
    fetch_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    drive(1, 32'h8000_4000, {32'h0080_0413, 32'h0090_0493}, 2'b00, 0, 0, 2'b00, 0);
    drive(0, 0, 0, 2'b00, 0, 0, 2'b11, 0);
    drive(0, 0, 0, 2'b00, 0, 0, 2'b00, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/biriscv_fetch_buffer.md
# biriscv_fetch_buffer

Parametrised instruction buffer between fetch and the N-wide decode/issue stage. Accepts fetch packets of FETCH_LANES 32-bit instructions and trims them to the live window: entry offset after a redirect, and cut after the first predicted-taken lane. Stores the live instructions as individual slots in a circular queue and presents up to ISSUE_LANES in-order instructions per cycle with per-lane accept. Flushes on branch redirect.

## Interface
- FETCH_LANES, 2, instructions per fetch packet (power of 2)
- ISSUE_LANES, 2, output lanes (≤ DEPTH)
- DEPTH, 8, queue slots (power of 2, ≥ FETCH_LANES)
- DEPTH_W, 3, log2(DEPTH)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- fetch_valid_i  in  1  packet valid
- fetch_instr_i  in  32*FETCH_LANES  lane k at bits [32k+31:32k]
- fetch_pc_i  in  32  PC of first live instruction (may be mid-packet)
- fetch_pred_branch_i  in  FETCH_LANES  per-lane predicted-taken
- fetch_fault_fetch_i, fetch_fault_page_i  in  1 each  packet fault flags
- fetch_accept_o  out  1  packet accepted this cycle
- flush_i  in  1  redirect; discard contents
- out_valid_o  out  ISSUE_LANES  per-lane valid
- out_instr_o, out_pc_o  out  32*ISSUE_LANES  per-lane instruction/PC
- out_pred_branch_o, out_fault_fetch_o, out_fault_page_o  out  ISSUE_LANES each
- out_accept_i  in  ISSUE_LANES  per-lane accept from issue
- level_o  out  DEPTH_W+1  occupied slots

## Operation
- Slot = {instr, pc, pred_branch, fault_fetch, fault_page}.
- Offset o = fetch_pc_i[LOG2(FETCH_LANES)+1:2]; lanes < o dropped. Lane k PC = {fetch_pc_i[31:LOG2(FETCH_LANES)+2], k, 2'b00}.
- Live lanes: o up to and including the first lane ≥ o with pred_branch set, otherwise up to FETCH_LANES-1. They are written contiguously at wr_ptr. Push count = number of live lanes (1..FETCH_LANES).
- Fault packet (either flag set): exactly one slot is pushed: instr 0, pc fetch_pc_i, pred 0, fault flags copied.
- fetch_accept_o = fetch_valid_i & (DEPTH - level ≥ FETCH_LANES). It is computed from the current level only; the same cycle's pop is not credited.
- Output lane k shows slot head+k when k < level.
- Fault rule: a fault slot is valid only on lane 0. If slot head+k with k>0 is a fault slot, lanes k.. are invalid.
- Pop count = number of leading lanes with out_valid_o & out_accept_i. Stop at the first lane not accepted; accepts on later lanes are ignored.
- Simultaneous push and pop are allowed: level_next = level + push - pop.
- Pointers are DEPTH_W bits and wrap modulo DEPTH. Level is DEPTH_W+1 bits and saturates exactly at DEPTH.
- flush_i: the next cycle has rd_ptr = wr_ptr = 0 and level = 0. Push and pop in the flush cycle are discarded. Flush has priority over everything.

## Timing
- Reset (rst_i low, async): pointers 0, level_o 0, out_valid_o 0, all data outputs 0, fetch_accept_o 0 while rst_i is low.
- Push-to-output latency: 1 cycle (slot visible the cycle after the accepting edge).
- Pop takes effect at the edge; the next slots appear the same following cycle.
- Full: fetch_accept_o low when fewer than FETCH_LANES slots are free, even if the packet would trim smaller.
- Empty: out_valid_o = 0. out_accept_i is ignored.
- Reset mid-operation: contents lost; no partial packet survives.

## Configuration
- BIRISCV_FETCH_BUF_BYPASS_EN defined:
  - When level = 0 and no flush, live lanes of an accepted packet drive the outputs combinationally in the same cycle (0-cycle latency).
  - Lanes accepted downstream are not written. The rest are written at wr_ptr as normal.
  - The fault lane-0 rule still applies.
- Undefined: no combinational path from fetch_* to out_*; latency is 1 cycle.

## Structure
- Package biriscv_fetch_buf_pkg: fetch_slot_t struct; INSTR_W = 32; PC_W = 32; function clog2.
- Sub-module biriscv_lane_compact (combinational):
  - Computes the live-lane mask, push count and compacted lane ordering from the offset and pred_branch.
  - Reused for the output leading-accept pop count.
- Top holds the slot array, pointers, level and the bypass mux.

## Test plan
Defaults: FETCH_LANES=2, ISSUE_LANES=2, DEPTH=8.
- Aligned push: pc 0x80000000, instr {0x00200113,0x00100093}. Next cycle: lane0 pc 0x80000000 instr 0x00100093; lane1 pc 0x80000004 instr 0x00200113; level 2.
- Mid-packet entry: pc 0x80000004. Result: level 1; out_valid 01; pc 0x80000004; instr = upper word.
- Predicted-taken cut: pc 0x80000000, pred 01. Result: lane1 dropped; level 1; out_pred_branch 01.
- Full/backpressure:
  - 4 packets pushed with no pop: level 8, fetch_accept_o 0.
  - Accept 01: level 7, fetch_accept_o still 0.
  - Accept 11: level 5, fetch_accept_o 1.
- Fault: push a normal slot at 0x80000000, then fault_page at 0x80001000.
  - Outputs: out_valid 01.
  - After pop: lane0 pc 0x80001000, instr 0, fault_page 1.
- Flush and wrap:
  - flush_i with simultaneous push and pop at level 5: next cycle level 0, out_valid 0.
  - Then 20 packets streamed with accept 11: PCs strictly sequential across pointer wrap.
